// File: rtl/rv32ima_pkg.sv
// Shared types for the machine-mode trap controller: exception event structs,
// trap cause codes, CSR addresses and the trap FSM state encoding.
package rv32ima_pkg;

  typedef struct packed {
    logic misaligned;
    logic access_fault;
  } inst_fetch_exception_t;

  typedef struct packed {
    logic illegal;
    logic ecall;
    logic ebreak;
  } decoder_exception_t;

  typedef struct packed {
    logic ld_misaligned;
    logic ld_fault;
    logic st_misaligned;
    logic st_fault;
  } ldst_exception_t;

  typedef enum logic [3:0] {
    CAUSE_FETCH_MISALIGNED = 4'd0,
    CAUSE_FETCH_FAULT      = 4'd1,
    CAUSE_ILLEGAL          = 4'd2,
    CAUSE_BREAKPOINT       = 4'd3,
    CAUSE_LD_MISALIGNED    = 4'd4,
    CAUSE_LD_FAULT         = 4'd5,
    CAUSE_ST_MISALIGNED    = 4'd6,
    CAUSE_ST_FAULT         = 4'd7,
    CAUSE_ECALL_M          = 4'd11
  } trap_cause_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    LOCKUP = 2'd2
  } trap_state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // Machine-only core: MPP always reads back as M-mode (2'b11).
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = 32'h0000_1800;
    v[MSTATUS_MIE_BIT]  = mie;
    v[MSTATUS_MPIE_BIT] = mpie;
    return v;
  endfunction

endpackage

// File: rtl/exception_if.sv
// Exception event bus between pipeline stages (publishers) and the trap controller (subscriber).
interface exception_if;
  import rv32ima_pkg::*;

  // Event flags are level-valid with no ready: a flag is consumed only in the cycle
  // the subscriber raises trap_enable; otherwise the publisher must re-present it.
  inst_fetch_exception_t fetch_exc;
  decoder_exception_t    dec_exc;
  ldst_exception_t       ldst_exc;
  logic [31:0]           current_pc;

  logic                  trap_enable;
  logic [31:0]           trap_handler_addr;
  logic [31:0]           epc_value;
  logic                  xret_enable;

  modport publisher (
    output fetch_exc, dec_exc, ldst_exc, current_pc,
    input  trap_enable, trap_handler_addr, epc_value, xret_enable
  );

  modport subscriber (
    input  fetch_exc, dec_exc, ldst_exc, current_pc,
    output trap_enable, trap_handler_addr, epc_value, xret_enable
  );

endinterface

// File: rtl/trap_priority_enc.sv
// Combinational priority encoder: exception event structs to {valid, cause, use_fault_addr}.
module trap_priority_enc
  import rv32ima_pkg::*;
(
  input  inst_fetch_exception_t i_fetch,
  input  decoder_exception_t    i_dec,
  input  ldst_exception_t       i_ldst,
  output logic                  o_valid,
  output trap_cause_t           o_cause,
  output logic                  o_use_fault_addr
);

  always_comb begin
    o_valid          = 1'b1;
    o_cause          = CAUSE_FETCH_MISALIGNED;
    o_use_fault_addr = 1'b0;
    // ecall sits below ebreak and above all load/store events.
    if (i_fetch.misaligned) begin
      o_cause = CAUSE_FETCH_MISALIGNED;  o_use_fault_addr = 1'b1;
    end else if (i_fetch.access_fault) begin
      o_cause = CAUSE_FETCH_FAULT;       o_use_fault_addr = 1'b1;
    end else if (i_dec.illegal) begin
      o_cause = CAUSE_ILLEGAL;
    end else if (i_dec.ebreak) begin
      o_cause = CAUSE_BREAKPOINT;
    end else if (i_dec.ecall) begin
      o_cause = CAUSE_ECALL_M;
    end else if (i_ldst.ld_misaligned) begin
      o_cause = CAUSE_LD_MISALIGNED;     o_use_fault_addr = 1'b1;
    end else if (i_ldst.ld_fault) begin
      o_cause = CAUSE_LD_FAULT;          o_use_fault_addr = 1'b1;
    end else if (i_ldst.st_misaligned) begin
      o_cause = CAUSE_ST_MISALIGNED;     o_use_fault_addr = 1'b1;
    end else if (i_ldst.st_fault) begin
      o_cause = CAUSE_ST_FAULT;          o_use_fault_addr = 1'b1;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl_unit.sv
// Machine-mode trap controller: event prioritisation, trap CSRs, MRET and lockup detection.
// Optional macro TRAP_MTVAL_EN: mtval captures the faulting address; otherwise mtval reads 0.
module trap_ctrl_unit
  import rv32ima_pkg::*;
#(
  parameter int          LOCKUP_LIMIT = 4,
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100
)(
  input  logic                  CLK,
  input  logic                  nRST,
  exception_if.subscriber       exc,
  input  logic                  stall,
  input  logic                  mret_inst,
  input  logic                  inst_retire,
  input  logic [31:0]           fault_addr,
  input  logic                  csr_wen,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_hit,
  output logic                  halt,
  output trap_state_t           dbg_state
);

  localparam int               CNT_W   = $clog2(LOCKUP_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCKUP_LIMIT);

  logic             w_evt_valid;
  trap_cause_t      w_cause;
  logic             w_use_fault;
  logic             w_active;
  logic             w_trap;
  logic             w_mret;
  logic             w_csr_wr_hold;
  trap_state_t      r_state;
  trap_state_t      w_state_next;
  logic [CNT_W-1:0] r_trap_cnt;
  logic [31:0]      r_mepc;
  logic [31:0]      r_mcause;
  logic [31:0]      r_mtvec;
  logic [31:0]      w_mtval;
  logic             r_mie;
  logic             r_mpie;

  trap_priority_enc u_prio (
    .i_fetch          (exc.fetch_exc),
    .i_dec            (exc.dec_exc),
    .i_ldst           (exc.ldst_exc),
    .o_valid          (w_evt_valid),
    .o_cause          (w_cause),
    .o_use_fault_addr (w_use_fault)
  );

  assign w_active      = (r_state == RUN) && !stall;
  assign w_trap        = w_active && w_evt_valid;
  assign w_mret        = w_active && mret_inst && !w_evt_valid;
  // A trap owns mepc/mcause/mtval/mstatus in its cycle; software writes to them are dropped.
  assign w_csr_wr_hold = csr_wen && !w_trap;

  assign exc.trap_enable       = w_trap;
  assign exc.trap_handler_addr = {r_mtvec[31:2], 2'b00};
  assign exc.xret_enable       = w_mret;
  assign exc.epc_value         = r_mepc;
  assign halt                  = (r_state == LOCKUP);
  assign dbg_state             = r_state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (w_trap) w_state_next = FLUSH;
      FLUSH:   w_state_next = (r_trap_cnt == CNT_MAX) ? LOCKUP : RUN;
      LOCKUP:  w_state_next = LOCKUP;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_trap_cnt <= '0;
    end else if (w_trap) begin
      if (inst_retire)              r_trap_cnt <= CNT_W'(1);
      else if (r_trap_cnt != CNT_MAX) r_trap_cnt <= r_trap_cnt + 1'b1;
    end else if (inst_retire) begin
      r_trap_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtvec  <= {RESET_MTVEC[31:2], 2'b00};
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
    end else begin
      if (csr_wen && csr_addr == CSR_MTVEC) r_mtvec <= {csr_wdata[31:2], 2'b00};
      if (w_trap) begin
        r_mepc   <= exc.current_pc;
        r_mcause <= {28'd0, w_cause};
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else begin
        if (w_mret) begin
          r_mie  <= r_mpie;
          r_mpie <= 1'b1;
        end else if (w_csr_wr_hold && csr_addr == CSR_MSTATUS) begin
          r_mie  <= csr_wdata[MSTATUS_MIE_BIT];
          r_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
        end
        if (w_csr_wr_hold && csr_addr == CSR_MEPC)   r_mepc   <= {csr_wdata[31:2], 2'b00};
        if (w_csr_wr_hold && csr_addr == CSR_MCAUSE) r_mcause <= csr_wdata;
      end
    end
  end

`ifdef TRAP_MTVAL_EN
  logic [31:0] r_mtval;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                           r_mtval <= '0;
    else if (w_trap)                                     r_mtval <= w_use_fault ? fault_addr : 32'd0;
    else if (w_csr_wr_hold && csr_addr == CSR_MTVAL)     r_mtval <= csr_wdata;
  end
  assign w_mtval = r_mtval;
`else
  logic w_unused_mtval_src;
  assign w_unused_mtval_src = ^{fault_addr, w_use_fault};
  assign w_mtval            = 32'd0;
`endif

  always_comb begin
    csr_hit   = 1'b1;
    csr_rdata = 32'd0;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus_pack(r_mie, r_mpie);
      CSR_MTVEC:   csr_rdata = r_mtvec;
      CSR_MEPC:    csr_rdata = r_mepc;
      CSR_MCAUSE:  csr_rdata = r_mcause;
      CSR_MTVAL:   csr_rdata = w_mtval;
      default:     csr_hit   = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl_unit.sv
// Scoreboard bench for trap_ctrl_unit: directed scenarios plus randomized traffic
// checked against a behavioural model of the trap rules.
module tb_trap_ctrl_unit;
  import rv32ima_pkg::*;

  localparam int W = 100;

  typedef struct packed {
    logic fm, fa, ill, ecall, ebreak, lm, lf, sm, sf;
    logic stall, mret, retire, wen;
    logic [31:0] pc;
    logic [31:0] fault;
    logic [11:0] addr;
    logic [31:0] wdata;
  } stim_t;

  // clock / reset
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  exception_if exc();
  logic        stall, mret_inst, inst_retire, csr_wen, csr_hit, halt;
  logic [31:0] fault_addr, csr_wdata, csr_rdata;
  logic [11:0] csr_addr;
  trap_state_t dbg_state;

  trap_ctrl_unit #(.LOCKUP_LIMIT(4), .RESET_MTVEC(32'h0000_0100)) dut (
    .CLK(CLK), .nRST(nRST), .exc(exc), .stall(stall), .mret_inst(mret_inst),
    .inst_retire(inst_retire), .fault_addr(fault_addr), .csr_wen(csr_wen),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_hit(csr_hit), .halt(halt), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model of the architectural state
  logic [31:0] m_mepc, m_mcause, m_mtval, m_mtvec;
  bit          m_mie, m_mpie, m_flush, m_locked;
  int          m_cnt;
  int          prio_cause[9] = '{0, 1, 2, 3, 11, 4, 5, 6, 7};

  function automatic void model_reset();
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mtvec = 32'h100;
    m_mie = 0; m_mpie = 0; m_flush = 0; m_locked = 0; m_cnt = 0;
  endfunction

  function automatic logic [32:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 19'd0, 2'b11, 3'd0, m_mpie, 3'd0, m_mie, 3'd0};
      12'h305: return {1'b1, m_mtvec};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h343: return {1'b1, m_mtval};
      default: return 33'd0;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.addr = 12'h7C0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exc.fetch_exc.misaligned   = s.fm;
    exc.fetch_exc.access_fault = s.fa;
    exc.dec_exc.illegal        = s.ill;
    exc.dec_exc.ecall          = s.ecall;
    exc.dec_exc.ebreak         = s.ebreak;
    exc.ldst_exc.ld_misaligned = s.lm;
    exc.ldst_exc.ld_fault      = s.lf;
    exc.ldst_exc.st_misaligned = s.sm;
    exc.ldst_exc.st_fault      = s.sf;
    exc.current_pc = s.pc;
    stall = s.stall; mret_inst = s.mret; inst_retire = s.retire;
    fault_addr = s.fault; csr_wen = s.wen; csr_addr = s.addr; csr_wdata = s.wdata;
  endtask

  // Push this cycle's expected outputs, then advance the model to the next cycle.
  task automatic model_cycle(input stim_t s, input bit in_reset);
    bit flags[9];
    bit any, can, trap, xret;
    int cause;
    logic [32:0] rd;
    flags = '{s.fm, s.fa, s.ill, s.ebreak, s.ecall, s.lm, s.lf, s.sm, s.sf};
    any = 0; cause = 0;
    for (int i = 8; i >= 0; i--) if (flags[i]) begin any = 1; cause = prio_cause[i]; end
    can  = !m_flush && !m_locked && !s.stall && !in_reset;
    trap = can && any;
    xret = can && s.mret && !any;
    rd   = model_read(s.addr);
    exp_q.push_back({trap, m_mtvec & 32'hFFFF_FFFC, xret, m_mepc, m_locked, rd});
    if (in_reset) return;
    if (m_flush) begin
      m_flush = 0;
      if (m_cnt == 4) m_locked = 1;
    end
    if (s.wen && s.addr == 12'h305) m_mtvec = s.wdata & 32'hFFFF_FFFC;
    if (trap) begin
      m_mepc = s.pc; m_mcause = cause;
      m_mpie = m_mie; m_mie = 0; m_flush = 1;
`ifdef TRAP_MTVAL_EN
      m_mtval = (cause inside {0, 1, 4, 5, 6, 7}) ? s.fault : 32'd0;
`endif
      m_cnt = s.retire ? 1 : ((m_cnt < 4) ? m_cnt + 1 : 4);
    end else begin
      if (xret) begin m_mie = m_mpie; m_mpie = 1; end
      else if (s.wen && s.addr == 12'h300) begin m_mie = s.wdata[3]; m_mpie = s.wdata[7]; end
      if (s.wen && s.addr == 12'h341) m_mepc = s.wdata & 32'hFFFF_FFFC;
      if (s.wen && s.addr == 12'h342) m_mcause = s.wdata;
`ifdef TRAP_MTVAL_EN
      if (s.wen && s.addr == 12'h343) m_mtval = s.wdata;
`endif
      if (s.retire) m_cnt = 0;
    end
  endtask

  // driver tasks
  task automatic step(input stim_t s);
    @(posedge CLK); #1;
    drive(s);
    model_cycle(s, 1'b0);
  endtask

  task automatic do_reset(input logic [11:0] rd_addr);
    stim_t s;
    s = idle(); s.addr = rd_addr;
    @(posedge CLK); #1;
    nRST = 1'b0;
    model_reset();
    drive(s);
    model_cycle(s, 1'b1);
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    logic [11:0] addrs[7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h000};
    s = idle();
    s.fm = ($urandom_range(0, 23) == 0); s.fa = ($urandom_range(0, 23) == 0);
    s.ill = ($urandom_range(0, 23) == 0); s.ecall = ($urandom_range(0, 15) == 0);
    s.ebreak = ($urandom_range(0, 23) == 0); s.lm = ($urandom_range(0, 23) == 0);
    s.lf = ($urandom_range(0, 23) == 0); s.sm = ($urandom_range(0, 23) == 0);
    s.sf = ($urandom_range(0, 23) == 0);
    s.stall = ($urandom_range(0, 6) == 0);
    s.mret = ($urandom_range(0, 5) == 0);
    s.retire = ($urandom_range(0, 2) == 0);
    s.pc = $urandom & 32'hFFFF_FFFC;
    s.fault = $urandom;
    s.wen = ($urandom_range(0, 4) == 0);
    s.addr = addrs[$urandom_range(0, 6)];
    s.wdata = $urandom;
    if (s.wen && s.addr == 12'h300) s.mret = 1'b0;
    return s;
  endfunction

  // monitor: compares every cycle that has an expectation queued
  always @(negedge CLK) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {exc.trap_enable, exc.trap_handler_addr, exc.xret_enable, exc.epc_value,
           halt, csr_hit, csr_rdata};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t addr=%h act te=%b h=%h x=%b epc=%h halt=%b hit=%b rd=%h exp te=%b h=%h x=%b epc=%h halt=%b hit=%b rd=%h",
                 $time, csr_addr, a[99], a[98:67], a[66], a[65:34], a[33], a[32], a[31:0],
                 e[99], e[98:67], e[66], e[65:34], e[33], e[32], e[31:0]);
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    drive(idle());
    do_reset(12'h305);
    s = idle(); s.addr = 12'h300; step(s);

    // illegal instruction with relocated mtvec
    s = idle(); s.wen = 1; s.addr = 12'h305; s.wdata = 32'h403; step(s);
    s = idle(); s.ill = 1; s.pc = 32'h2000; s.addr = 12'h305; step(s);
    s = idle(); s.ecall = 1; s.addr = 12'h341; step(s);
    s = idle(); s.addr = 12'h342; step(s);
    s = idle(); s.addr = 12'h300; s.ecall = 1; s.stall = 1; step(s);

    // simultaneous fetch misaligned + load fault
    s = idle(); s.fm = 1; s.lf = 1; s.pc = 32'h2100; s.fault = 32'h77; s.retire = 1; step(s);
    s = idle(); s.addr = 12'h342; step(s);

    // MRET after a trap taken with MIE=1
    s = idle(); s.wen = 1; s.addr = 12'h300; s.wdata = 32'h8; step(s);
    s = idle(); s.ebreak = 1; s.pc = 32'h3000; s.addr = 12'h300; step(s);
    s = idle(); s.addr = 12'h300; step(s);
    s = idle(); s.mret = 1; s.addr = 12'h300; step(s);
    s = idle(); s.addr = 12'h300; step(s);
    s = idle(); s.mret = 1; s.ecall = 1; s.pc = 32'h3400; s.addr = 12'h342; step(s);
    s = idle(); s.addr = 12'h342; step(s);

    // reset in the FLUSH cycle
    s = idle(); s.ill = 1; s.pc = 32'h4000; s.retire = 1; step(s);
    do_reset(12'h305);
    s = idle(); s.addr = 12'h341; step(s);

    // lockup after four traps without a retire
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.ebreak = 1; s.pc = 32'h5000 + 4 * i; step(s);
      s = idle(); step(s);
    end
    s = idle(); s.ecall = 1; s.addr = 12'h341; step(s);
    s = idle(); s.mret = 1; step(s);
    do_reset(12'h300);

    // a retire between traps restarts the count
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.ebreak = 1; s.pc = 32'h5100 + 4 * i; step(s);
      s = idle(); s.retire = (i == 1); step(s);
    end
    s = idle(); s.ecall = 1; s.retire = 1; step(s);

    // store misaligned fault address and a dropped mepc write in the trap cycle
    s = idle(); step(s);
    s = idle(); s.sm = 1; s.fault = 32'h1003; s.pc = 32'h6000; s.wen = 1; s.addr = 12'h341;
    s.wdata = 32'h5554; s.retire = 1; step(s);
    s = idle(); s.addr = 12'h343; step(s);
    s = idle(); s.addr = 12'h341; step(s);
    s = idle(); s.wen = 1; s.addr = 12'h343; s.wdata = 32'hABCD_0001; step(s);
    s = idle(); s.addr = 12'h343; step(s);
    s = idle(); s.addr = 12'h344; s.wen = 1; s.wdata = 32'hFFFF_FFFF; step(s);

    // randomized traffic with periodic resets
    for (int blk = 0; blk < 30; blk++) begin
      int len;
      len = $urandom_range(20, 80);
      for (int i = 0; i < len; i++) step(rand_stim());
      do_reset(12'h305);
    end

    repeat (3) @(posedge CLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain act=%0d pending exp=0 pending", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
